// File: rtl/or_gate_df_pkg.sv
// Shared definitions for or_gate_df: hit-counter width, saturation limit and increment helper.
`timescale 1ns/1ps
package or_gate_df_pkg;

    localparam int HIT_CNT_W = 16;
    localparam logic [HIT_CNT_W-1:0] HIT_CNT_MAX = 16'hFFFF;

    typedef logic [HIT_CNT_W-1:0] hit_cnt_t;

    // Increment that sticks at the top value instead of wrapping.
    function automatic hit_cnt_t hit_cnt_sat_inc(input hit_cnt_t cur);
        hit_cnt_t nxt;
        if (cur == HIT_CNT_MAX) begin
            nxt = cur;
        end else begin
            nxt = cur + hit_cnt_t'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/or_gate_df_core.sv
// Purely combinational WIDTH-bit bitwise OR with an "any bit set" reduction.
`timescale 1ns/1ps
module or_gate_df_core #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             y_any
);

    assign y     = a | b;
    assign y_any = |y;

endmodule

// File: rtl/or_gate_df.sv
// Bitwise OR with combinational and registered (valid-qualified) outputs plus a sticky accumulator.
// Optional hit counter enabled by defining OR_GATE_DF_STATS_EN.
`timescale 1ns/1ps
module or_gate_df
    import or_gate_df_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 in_valid,
    input  logic                 acc_clr,
    output logic [WIDTH-1:0]     y,
    output logic                 y_any,
    output logic [WIDTH-1:0]     y_q,
    output logic                 out_valid,
`ifdef OR_GATE_DF_STATS_EN
    output logic [HIT_CNT_W-1:0] hit_cnt,
`endif
    output logic [WIDTH-1:0]     acc
);

    // Handshake: in_valid=1 at a rising edge means a/b are taken that edge; there is no
    // ready, every valid cycle is accepted. out_valid is high for exactly one cycle per
    // accepted input, one cycle later, and y_q holds that result until the next accept.

    or_gate_df_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a     (a),
        .b     (b),
        .y     (y),
        .y_any (y_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                y_q <= y;
            end
        end
    end

    // Clear has priority so a flush cycle never leaks its own operand into acc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (acc_clr) begin
            acc <= '0;
        end else if (in_valid) begin
            acc <= acc | y;
        end
    end

`ifdef OR_GATE_DF_STATS_EN
    hit_cnt_t hit_cnt_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_r <= '0;
        end else if (acc_clr) begin
            hit_cnt_r <= '0;
        end else if (in_valid && y_any) begin
            hit_cnt_r <= hit_cnt_sat_inc(hit_cnt_r);
        end
    end

    assign hit_cnt = hit_cnt_r;
`endif

endmodule

// File: tb/tb_or_gate_df.sv
// Directed, table-driven bench for or_gate_df (WIDTH=1 gate and WIDTH=8 registered path).
`timescale 1ns/1ps
module tb_or_gate_df;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- WIDTH=1 instance ----------------
    logic a1, b1, v1, c1;
    logic y1, y_any1, y_q1, ov1, acc1;
`ifdef OR_GATE_DF_STATS_EN
    logic [15:0] hit_cnt1;
`endif

    or_gate_df #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a1),
        .b         (b1),
        .in_valid  (v1),
        .acc_clr   (c1),
        .y         (y1),
        .y_any     (y_any1),
        .y_q       (y_q1),
        .out_valid (ov1),
`ifdef OR_GATE_DF_STATS_EN
        .hit_cnt   (hit_cnt1),
`endif
        .acc       (acc1)
    );

    // ---------------- WIDTH=8 instance ----------------
    logic [7:0] a, b;
    logic       in_valid, acc_clr;
    logic [7:0] y, y_q, acc;
    logic       y_any, out_valid;
`ifdef OR_GATE_DF_STATS_EN
    logic [15:0] hit_cnt;
`endif

    or_gate_df #(.WIDTH(8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .acc_clr   (acc_clr),
        .y         (y),
        .y_any     (y_any),
        .y_q       (y_q),
        .out_valid (out_valid),
`ifdef OR_GATE_DF_STATS_EN
        .hit_cnt   (hit_cnt),
`endif
        .acc       (acc)
    );

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called after each edge: a fresh out_valid must match the oldest accepted result.
    task automatic sb_check();
        logic [7:0] exp_y;
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_valid", 32'(out_valid), 32'd0);
            end else begin
                exp_y = exp_q.pop_front();
                check("sb_y_q", 32'(y_q), 32'(exp_y));
            end
        end else begin
            check("sb_pending", 32'(exp_q.size()), 32'd0);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Drive one cycle on the WIDTH=8 instance: set inputs at negedge, advance to posedge+1.
    task automatic drive(input logic [7:0] da, input logic [7:0] db, input logic dv, input logic dc);
        @(negedge clk);
        a        = da;
        b        = db;
        in_valid = dv;
        acc_clr  = dc;
        if (dv) exp_q.push_back(da | db);
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag, input logic [7:0] e_yq, input logic e_ov,
                              input logic [7:0] e_acc);
        check({tag, "_y_q"}, 32'(y_q), 32'(e_yq));
        check({tag, "_out_valid"}, 32'(out_valid), 32'(e_ov));
        check({tag, "_acc"}, 32'(acc), 32'(e_acc));
    endtask

    // ---------------- vector tables ----------------
    typedef struct {
        logic a;
        logic b;
        int   hold_ns;
        logic e_y;
    } tt_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       v;
        logic       c;
        logic [7:0] e_yq;
        logic       e_ov;
        logic [7:0] e_acc;
    } vec_t;

    tt_t  tt[4];
    vec_t tbl[8];

    initial begin
        tt[0] = '{1'b0, 1'b0, 10, 1'b0};
        tt[1] = '{1'b0, 1'b1, 20, 1'b1};
        tt[2] = '{1'b1, 1'b0, 40, 1'b1};
        tt[3] = '{1'b1, 1'b1, 60, 1'b1};

        tbl[0] = '{8'h0F, 8'hF0, 1'b1, 1'b0, 8'hFF, 1'b1, 8'hFF};
        tbl[1] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0, 8'hFF};
        tbl[2] = '{8'h12, 8'h34, 1'b0, 1'b1, 8'hFF, 1'b0, 8'h00};
        tbl[3] = '{8'h01, 8'h00, 1'b1, 1'b0, 8'h01, 1'b1, 8'h01};
        tbl[4] = '{8'h80, 8'h00, 1'b1, 1'b0, 8'h80, 1'b1, 8'h81};
        tbl[5] = '{8'hFF, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b1, 8'h00};
        tbl[6] = '{8'h01, 8'h00, 1'b1, 1'b0, 8'h01, 1'b1, 8'h01};
        tbl[7] = '{8'h00, 8'h80, 1'b1, 1'b0, 8'h80, 1'b1, 8'h81};

        rst_n = 1'b0;
        a1 = 1'b0; b1 = 1'b0; v1 = 1'b0; c1 = 1'b0;
        a = 8'h00; b = 8'h00; in_valid = 1'b0; acc_clr = 1'b0;

        // WIDTH=1 truth table, applied while still in reset: y must not depend on rst_n.
        for (int i = 0; i < 4; i++) begin
            a1 = tt[i].a;
            b1 = tt[i].b;
            #(tt[i].hold_ns);
            check($sformatf("tt%0d_y", i), 32'(y1), 32'(tt[i].e_y));
            check($sformatf("tt%0d_y_any", i), 32'(y_any1), 32'(tt[i].e_y));
        end

        check_regs("reset", 8'h00, 1'b0, 8'h00);
        check("reset_w1_out_valid", 32'(ov1), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_regs("release", 8'h00, 1'b0, 8'h00);

        // Registered path and accumulator from the vector table.
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].a, tbl[i].b, tbl[i].v, tbl[i].c);
            check($sformatf("row%0d_y", i), 32'(y), 32'(tbl[i].a | tbl[i].b));
            check($sformatf("row%0d_y_any", i), 32'(y_any), 32'(|(tbl[i].a | tbl[i].b)));
            check_regs($sformatf("row%0d", i), tbl[i].e_yq, tbl[i].e_ov, tbl[i].e_acc);
            sb_check();
        end

        // Async reset between edges while out_valid=1 and acc=8'h81.
        #3;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_regs("async_rst", 8'h00, 1'b0, 8'h00);
        check("async_rst_y", 32'(y), 32'h80);
        exp_q.delete();
        a = 8'h3C;
        b = 8'h41;
        #1;
        check("rst_y_live", 32'(y), 32'h7D);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_regs("post_rst_idle", 8'h00, 1'b0, 8'h00);
        sb_check();
        drive(8'h5A, 8'h00, 1'b1, 1'b0);
        check_regs("post_rst_accept", 8'h5A, 1'b1, 8'h5A);
        sb_check();
        drive(8'h00, 8'h00, 1'b0, 1'b0);
        check_regs("post_rst_drop", 8'h5A, 1'b0, 8'h5A);

`ifdef OR_GATE_DF_STATS_EN
        drive(8'h00, 8'h00, 1'b0, 1'b1);
        check("stats_clear", 32'(hit_cnt), 32'd0);
        drive(8'h01, 8'h00, 1'b1, 1'b0);
        drive(8'h00, 8'h20, 1'b1, 1'b0);
        drive(8'h00, 8'h00, 1'b1, 1'b0);
        drive(8'hC0, 8'h03, 1'b1, 1'b0);
        check("stats_three_hits", 32'(hit_cnt), 32'd3);
        exp_q.delete();
        // 65532 more hits reach 16'hFFFF; the extra ones must not wrap.
        for (int i = 0; i < 65537; i++) begin
            @(negedge clk);
            a = 8'h04; b = 8'h00; in_valid = 1'b1; acc_clr = 1'b0;
        end
        @(posedge clk);
        #1;
        check("stats_saturate", 32'(hit_cnt), 32'h0000FFFF);
        drive(8'hFF, 8'h00, 1'b1, 1'b1);
        check("stats_clr_wins", 32'(hit_cnt), 32'd0);
        check("stats_clr_acc", 32'(acc), 32'd0);
        exp_q.delete();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/or_gate_df.md
Name: or_gate_df

Overview:
- Dataflow two-operand bitwise OR block with a combinational output path and a registered, valid-qualified output path.
- Adds a sticky OR accumulator and a reduction "any bit set" flag.
- Primitive logic building block used by glue logic and flag-merging paths; the default WIDTH=1 reduces to a plain 2-input OR gate.

Parameters:
- WIDTH, 1, operand and result bit width (legal range 1..64).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- in_valid  input  1  qualifies a/b for the registered path.
- acc_clr  input  1  synchronous clear of the accumulator.
- y  output  WIDTH  combinational result a | b.
- y_any  output  1  combinational reduction OR of y.
- y_q  output  WIDTH  registered result.
- out_valid  output  1  y_q holds a fresh result this cycle.
- acc  output  WIDTH  sticky OR of every accepted result since the last clear or reset.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- y = a | b, bitwise. Purely combinational, zero latency, independent of clk/rst_n, so it is valid during reset.
- y_any = |y. Combinational.
- Registered path, on each rising edge with in_valid=1:
  - y_q <= a | b
  - out_valid <= 1
- On each edge with in_valid=0: out_valid <= 0 and y_q holds its value.
- Latency: 1 cycle from an accepted input to y_q/out_valid.
- Accumulator, on each edge:
  - acc_clr=1: acc <= 0, regardless of in_valid (clear wins over a simultaneous accept).
  - else in_valid=1: acc <= acc | a | b.
  - else acc holds.
- Reset (rst_n=0, asynchronous assert): y_q=0, out_valid=0, acc=0 immediately. Deassertion takes effect at the next rising edge.
- Reset asserted mid-stream: the in-flight result is discarded; out_valid=0 on the first cycle after release unless in_valid=1 at that edge.
- No backpressure: every in_valid cycle is accepted.
- X on a or b propagates per bit. An X on in_valid is a bench error.

Optional Feature:
- Macro: OR_GATE_DF_STATS_EN.
- When defined, adds output hit_cnt (16 bits):
  - Increments on each accepted cycle (in_valid=1) where a|b != 0.
  - Saturates at 16'hFFFF.
  - Cleared by rst_n and by acc_clr; clear wins over a simultaneous increment.
- When undefined: the hit_cnt port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package or_gate_df_pkg:
  - localparam HIT_CNT_W = 16
  - localparam HIT_CNT_MAX = 16'hFFFF
  - typedef for the counter type
- One natural sub-module: or_gate_df_core, a purely combinational WIDTH-bit OR plus reduction. The top wraps it with the registers, accumulator and optional stats.

Test Plan:
- WIDTH=1 truth table, combinational: a/b = 0/0, 0/1, 1/0, 1/1, each held for 10, 20, 40, 60 ns respectively -> y = 0, 1, 1, 1; y_any tracks y.
- Registered path, WIDTH=8, in_valid=1: a=8'h0F, b=8'hF0 -> next edge y_q=8'hFF, out_valid=1. Then in_valid=0 -> out_valid=0, y_q stays 8'hFF.
- Accumulator: accept a=8'h01,b=0; then a=8'h80,b=0 -> acc=8'h81. Then acc_clr=1 together with in_valid=1 and a=8'hFF -> acc=8'h00.
- Async reset mid-stream: assert rst_n=0 between edges while out_valid=1 and acc=8'h81 -> y_q, out_valid, acc go to 0 immediately. y remains a|b throughout.
- With OR_GATE_DF_STATS_EN: 3 accepted nonzero results plus 1 accepted all-zero result -> hit_cnt=3. Preload the counter near 16'hFFFF and drive further hits -> hit_cnt saturates at 16'hFFFF; acc_clr -> hit_cnt=0.
